// File: rtl/ufb_pkg.sv
// Shared mode encodings and the per-bit next-state rule for the universal flip-flop bank.
package ufb_pkg;

   typedef enum logic [1:0] {
      MODE_D  = 2'b00,
      MODE_T  = 2'b01,
      MODE_JK = 2'b10,
      MODE_SR = 2'b11
   } ufb_mode_e;

   // S=R=1 in SR mode holds the bit; the violation itself is flagged by the caller.
   function automatic logic ufb_next(input logic [1:0] mode, input logic a, input logic b,
                                     input logic q);
      logic nq;
      nq = q;
      case (ufb_mode_e'(mode))
         MODE_D:  nq = a;
         MODE_T:  nq = a ? ~q : q;
         MODE_JK: begin
            case ({a, b})
               2'b01:   nq = 1'b0;
               2'b10:   nq = 1'b1;
               2'b11:   nq = ~q;
               default: nq = q;
            endcase
         end
         MODE_SR: begin
            case ({a, b})
               2'b01:   nq = 1'b0;
               2'b10:   nq = 1'b1;
               default: nq = q;
            endcase
         end
         default: nq = q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/ufb_cell.sv
// One bit of the bank: q, independently registered q_bar, and a one-cycle change flag.
module ufb_cell
   import ufb_pkg::*;
#(
   parameter logic RST_BIT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   output logic       q,
   output logic       q_bar,
   output logic       toggled,
   output logic       chg,
   output logic       viol
);

   logic q_p1;
   logic qb_p1;
   logic tog_p1;
   logic nq;

   assign nq   = ufb_next(mode, a, b, q_p1);
   // chg is already gated by en, so it doubles as the next toggled value.
   assign chg  = en & (nq ^ q_p1);
   assign viol = en & (ufb_mode_e'(mode) == MODE_SR) & a & b;

   // Stage p1: state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_p1   <= RST_BIT;
         qb_p1  <= ~RST_BIT;
         tog_p1 <= 1'b0;
      end else begin
         tog_p1 <= chg;
         if (en) begin
            q_p1  <= nq;
            qb_p1 <= ~nq;
         end
      end
   end

   assign q       = q_p1;
   assign q_bar   = qb_p1;
   assign toggled = tog_p1;

endmodule

// File: rtl/universal_ff_bank.sv
// WIDTH-bit bank of D/T/JK/SR flip-flops with change counting and sticky SR-violation flag.
module universal_ff_bank
   import ufb_pkg::*;
#(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
   parameter int                 CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [WIDTH-1:0] toggled,
   output logic [CNT_W-1:0] chg_cnt,
   output logic             sr_err
);

   logic [WIDTH-1:0] chg;
   logic [WIDTH-1:0] viol;
   logic [CNT_W-1:0] cnt_p1;
   logic             err_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ufb_cell #(
         .RST_BIT (RESET_VAL[i])
      ) u_cell (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .mode    (mode),
         .a       (a[i]),
         .b       (b[i]),
         .q       (q[i]),
         .q_bar   (q_bar[i]),
         .toggled (toggled[i]),
         .chg     (chg[i]),
         .viol    (viol[i])
      );
   end

   // Stage p1: bank-wide counter and sticky flag; a new violation beats err_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_p1 <= '0;
         err_p1 <= 1'b0;
      end else begin
         if (|chg) cnt_p1 <= sat_inc(cnt_p1);
         if (|viol)        err_p1 <= 1'b1;
         else if (err_clr) err_p1 <= 1'b0;
      end
   end

   assign chg_cnt = cnt_p1;
   assign sr_err  = err_p1;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Randomised and directed bench for universal_ff_bank against a vector-level reference model.
module tb_universal_ff_bank;

   localparam int         WIDTH     = 8;
   localparam logic [7:0] RESET_VAL = 8'hA5;
   localparam int         CNT_W     = 8;
   localparam int         CNT_MAX   = 255;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             err_clr = 1'b0;
   logic [WIDTH-1:0] q, q_bar, toggled;
   logic [CNT_W-1:0] chg_cnt;
   logic             sr_err;

   universal_ff_bank #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q), .q_bar(q_bar), .toggled(toggled), .chg_cnt(chg_cnt), .sr_err(sr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [7:0] m_q   = RESET_VAL;
   logic [7:0] m_tog = 8'h00;
   int         m_cnt = 0;
   logic       m_err = 1'b0;

   // Characteristic equations applied to the whole vector at once.
   function automatic logic [7:0] model_next(input logic [1:0] md, input logic [7:0] av,
                                              input logic [7:0] bv, input logic [7:0] qv);
      case (md)
         2'd0:    return av;
         2'd1:    return qv ^ av;
         2'd2:    return (av & ~qv) | (~bv & qv);
         default: return (av & ~bv) | (qv & ~(av ^ bv));
      endcase
   endfunction

   task automatic model_reset();
      m_q = RESET_VAL; m_tog = 8'h00; m_cnt = 0; m_err = 1'b0;
   endtask

   // Drive one cycle of inputs, take the edge, then advance the model.
   task automatic tick(input logic e, input logic [1:0] md, input logic [7:0] av,
                       input logic [7:0] bv, input logic ec);
      logic [7:0] nq;
      en = e; mode = md; a = av; b = bv; err_clr = ec;
      nq = model_next(md, av, bv, m_q);
      @(posedge clk);
      #1;
      if (e) begin
         m_tog = nq ^ m_q;
         if (m_tog != 8'h00 && m_cnt < CNT_MAX) m_cnt++;
         m_q = nq;
         if (md == 2'd3 && (av & bv) != 8'h00) m_err = 1'b1;
         else if (ec) m_err = 1'b0;
      end else begin
         m_tog = 8'h00;
         if (ec) m_err = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({q, q_bar, toggled, chg_cnt, sr_err} !== {8'hA5, 8'h5A, 8'h00, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset: q=%h qb=%h tog=%h cnt=%0d err=%b want q=a5 qb=5a tog=00 cnt=0 err=0",
                  q, q_bar, toggled, chg_cnt, sr_err);
      end
      model_reset();
      rst = 1'b0;
   endtask

   task automatic test_jk();
      logic [7:0] exp_q [3];
      exp_q[0] = 8'h5A; exp_q[1] = 8'hA5; exp_q[2] = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 2'd2, 8'hFF, 8'hFF, 1'b0);
         checks++;
         if (q !== exp_q[i] || q_bar !== ~exp_q[i] || toggled !== 8'hFF ||
             chg_cnt !== 8'(i + 1) || q_bar !== ~q) begin
            errors++;
            $display("FAIL jk_toggle[%0d]: q=%h qb=%h tog=%h cnt=%0d want q=%h qb=%h tog=ff cnt=%0d",
                     i, q, q_bar, toggled, chg_cnt, exp_q[i], ~exp_q[i], i + 1);
         end
      end
   endtask

   task automatic test_t_saturate();
      for (int i = 0; i < 300; i++) begin
         tick(1'b1, 2'd1, 8'h01, 8'($urandom), 1'b0);
         checks++;
         if (q !== m_q || q_bar !== ~m_q || toggled !== m_tog || chg_cnt !== 8'(m_cnt)) begin
            errors++;
            $display("FAIL t_mode[%0d]: q=%h qb=%h tog=%h cnt=%0d want q=%h qb=%h tog=%h cnt=%0d",
                     i, q, q_bar, toggled, chg_cnt, m_q, ~m_q, m_tog, m_cnt);
         end
      end
      checks++;
      if (chg_cnt !== 8'd255 || q !== 8'h5A) begin
         errors++;
         $display("FAIL t_saturate: cnt=%0d q=%h want cnt=255 q=5a", chg_cnt, q);
      end
   endtask

   task automatic test_sr();
      tick(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
      tick(1'b1, 2'd3, 8'h0F, 8'h03, 1'b0);
      checks++;
      if (q !== 8'h0C || q_bar !== 8'hF3 || toggled !== 8'h0C || sr_err !== 1'b1) begin
         errors++;
         $display("FAIL sr_set: q=%h qb=%h tog=%h err=%b want q=0c qb=f3 tog=0c err=1",
                  q, q_bar, toggled, sr_err);
      end
      tick(1'b1, 2'd3, 8'h01, 8'h01, 1'b1);
      checks++;
      if (sr_err !== 1'b1 || q !== 8'h0C) begin
         errors++;
         $display("FAIL sr_set_wins: err=%b q=%h want err=1 q=0c", sr_err, q);
      end
      tick(1'b1, 2'd3, 8'h00, 8'h00, 1'b1);
      checks++;
      if (sr_err !== 1'b0 || q !== 8'h0C || toggled !== 8'h00) begin
         errors++;
         $display("FAIL sr_clear: err=%b q=%h tog=%h want err=0 q=0c tog=00", sr_err, q, toggled);
      end
      tick(1'b0, 2'd3, 8'hFF, 8'hFF, 1'b0);
      checks++;
      if (sr_err !== 1'b0) begin
         errors++;
         $display("FAIL sr_gated_by_en: err=%b want 0", sr_err);
      end
      tick(1'b1, 2'd3, 8'h80, 8'h80, 1'b0);
      tick(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
      checks++;
      if (sr_err !== 1'b0 || q !== 8'h0C) begin
         errors++;
         $display("FAIL clr_without_en: err=%b q=%h want err=0 q=0c", sr_err, q);
      end
   endtask

   task automatic test_enable();
      int cnt0;
      logic [7:0] q0;
      cnt0 = int'(chg_cnt);
      q0   = q;
      tick(1'b0, 2'd0, 8'h3C, 8'hFF, 1'b0);
      checks++;
      if (q !== q0 || q_bar !== ~q0 || toggled !== 8'h00 || int'(chg_cnt) !== cnt0) begin
         errors++;
         $display("FAIL en_hold: q=%h tog=%h cnt=%0d want q=%h tog=00 cnt=%0d",
                  q, toggled, chg_cnt, q0, cnt0);
      end
      tick(1'b1, 2'd0, 8'h3C, 8'hFF, 1'b0);
      checks++;
      if (q !== 8'h3C || q_bar !== 8'hC3 || toggled !== (q0 ^ 8'h3C)) begin
         errors++;
         $display("FAIL en_load: q=%h qb=%h tog=%h want q=3c qb=c3 tog=%h",
                  q, q_bar, toggled, q0 ^ 8'h3C);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
              8'($urandom), ($urandom_range(0, 7) == 0));
         checks++;
         if ({q, q_bar, toggled, chg_cnt, sr_err} !== {m_q, ~m_q, m_tog, 8'(m_cnt), m_err}) begin
            errors++;
            $display("FAIL random[%0d]: q=%h qb=%h tog=%h cnt=%0d err=%b want q=%h qb=%h tog=%h cnt=%0d err=%b",
                     i, q, q_bar, toggled, chg_cnt, sr_err, m_q, ~m_q, m_tog, m_cnt, m_err);
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 2'd3, 8'h11, 8'h11, 1'b0);
      tick(1'b1, 2'd0, 8'h5F, 8'h00, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({q, q_bar, toggled, chg_cnt, sr_err} !== {8'hA5, 8'h5A, 8'h00, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: q=%h qb=%h tog=%h cnt=%0d err=%b want q=a5 qb=5a tog=00 cnt=0 err=0",
                  q, q_bar, toggled, chg_cnt, sr_err);
      end
      model_reset();
      rst = 1'b0;
      tick(1'b1, 2'd0, 8'hFF, 8'h00, 1'b0);
      checks++;
      if (q !== 8'hFF || q_bar !== 8'h00 || toggled !== 8'h5A || chg_cnt !== 8'd1 || sr_err !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: q=%h qb=%h tog=%h cnt=%0d err=%b want q=ff qb=00 tog=5a cnt=1 err=0",
                  q, q_bar, toggled, chg_cnt, sr_err);
      end
   endtask

   initial begin
      test_reset();
      test_jk();
      test_t_saturate();
      test_sr();
      test_enable();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/universal_ff_bank.md
Name: universal_ff_bank

Overview:
- Parametrised WIDTH-bit register bank. Each bit behaves as a D, T, JK or SR flip-flop, selected by a shared runtime mode input.
- Successor to the single-bit JK flip-flop: adds width, a clock enable, an asynchronous reset, per-bit change flags, a saturating change-event counter, and sticky detection of the illegal SR input.
- Serves as the generic storage/toggle element for the counter and shift-register blocks built on top of it.

Parameters:
- WIDTH, 8, number of flip-flop bits.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, 8, width of the change-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock enable. When 0, all state holds.
- mode  input  2  flip-flop type: 00 D, 01 T, 10 JK, 11 SR.
- a  input  WIDTH  per-bit D / T / J / S input, depending on mode.
- b  input  WIDTH  per-bit K / R input. Ignored in D and T modes.
- err_clr  input  1  synchronous clear of sr_err.
- q  output  WIDTH  registered state.
- q_bar  output  WIDTH  registered complement of q.
- toggled  output  WIDTH  registered; bit i is 1 for one cycle after q[i] changed.
- chg_cnt  output  CNT_W  count of enabled edges on which at least one bit changed. Saturates at max.
- sr_err  output  1  sticky flag: SR mode was applied with S=R=1 on some bit.

Behaviour:
- Reset (rst=1, asynchronous, immediate, overrides everything):
  - q=RESET_VAL, q_bar=~RESET_VAL.
  - toggled=0, chg_cnt=0, sr_err=0.
- Rising clk edge with en=1, per bit i, next value nq[i]:
  - D: nq=a.
  - T: nq = a ? ~q : q.
  - JK: 00 hold; 01 → 0; 10 → 1; 11 → ~q.
  - SR: 00 hold; 01 → 0; 10 → 1; 11 → hold, and this bit counts as an SR violation.
- q_bar is a separately registered ~nq, never a swap of q. q_bar==~q holds at all times, including during and after reset.
- Latency: one clock from inputs to q, q_bar, toggled, chg_cnt and sr_err.
- toggled <= nq ^ q on an enabled edge. toggled <= 0 on any edge with en=0.
- chg_cnt increments by 1 when (nq ^ q) != 0 and en=1. It holds at 2^CNT_W-1 (no wrap).
- sr_err:
  - Set when en=1, mode=SR and (a & b) != 0.
  - Cleared by err_clr=1 on an edge.
  - Set and clear on the same edge: set wins.
  - err_clr works regardless of en.
- en=0: q, q_bar and chg_cnt hold. No SR violation is detected.
- Mode changes take effect on the next edge. No state is reset by a mode change.
- Unused b bits in D/T modes must not affect any output.
- Reset asserted mid-operation clears all state asynchronously. The first enabled edge after deassertion evaluates from RESET_VAL.

Decomposition:
- Package ufb_pkg:
  - mode encodings MODE_D=2'b00, MODE_T=2'b01, MODE_JK=2'b10, MODE_SR=2'b11.
  - function ufb_next(mode, a, b, q) returning the next-state bit.
- Sub-module ufb_cell: one bit's q/q_bar/toggled registers plus a violation output.
  - Instantiated WIDTH times via generate.
  - Top level holds chg_cnt, the sr_err reduction and the sticky logic.

Test Plan:
- Reset with WIDTH=8, RESET_VAL=8'hA5 → q=8'hA5, q_bar=8'h5A, toggled=0, chg_cnt=0, sr_err=0, immediately without a clock.
- JK mode, a=8'hFF, b=8'hFF for 3 edges from q=8'hA5 → q: 5A, A5, 5A; toggled=8'hFF each cycle; chg_cnt=3; q_bar==~q on every cycle.
- T mode, a=8'h01, 300 edges, CNT_W=8 → q[0] alternates, other bits hold; chg_cnt saturates at 255.
- SR mode, a=8'h0F, b=8'h03 from q=8'h00 → q=8'h0C, toggled=8'h0C, sr_err=1. Next edge err_clr=1 with a=b=8'h01 → sr_err stays 1 (set wins). Next edge err_clr=1 with a=b=0 → sr_err=0.
- en=0 with D mode, a=8'h3C → q unchanged, toggled=0, chg_cnt unchanged. Raise en → q=8'h3C after one edge.
- Assert rst between clock edges mid-sequence → all outputs return to reset values at once. First edge after release (D, a=8'hFF) → q=8'hFF, chg_cnt=1.
